eth_pcs_tx_scrambler: RTL and testbench

//  TX PCS stage between the 64b/66b encoder and the TX gearbox. Scrambles the block payload with the

---
 rtl/eth_pcs_tx_scrambler_pkg.sv | 27 ++
 rtl/eth_pcs_tx_scrambler_prbs31_gen.sv | 53 +++++
 rtl/eth_pcs_tx_scrambler.sv | 116 +++++++++++
 tb/tb_eth_pcs_tx_scrambler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pcs_tx_scrambler_pkg.sv
// Shared types and constants for the 10GBASE-R TX scrambler slice.
// Mode encodings, LFSR lengths/taps and the mode sanitising helper.
package eth_pcs_tx_scrambler_pkg;

  typedef enum logic [1:0] {
    TX_MODE_NORMAL = 2'b00,
    TX_MODE_PRBS31 = 2'b01,
    TX_MODE_BYPASS = 2'b10
  } tx_test_mode_e;

  localparam int SCR_LEN  = 58;
  localparam int SCR_TAP  = 39;
  localparam int PRBS_LEN = 31;
  localparam int PRBS_TAP = 28;

  // The unused 2'b11 encoding falls back to normal scrambling.
  function automatic tx_test_mode_e to_tx_mode(input logic [1:0] raw);
    tx_test_mode_e m;
    case (raw)
      2'b01:   m = TX_MODE_PRBS31;
      2'b10:   m = TX_MODE_BYPASS;
      default: m = TX_MODE_NORMAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/eth_pcs_tx_scrambler_prbs31_gen.sv
// Parallel PRBS31 (1+x^28+x^31) generator producing W_DATA+W_SYNC bits per cycle,
// MSB first on the wire; advances by the wide or narrow count when i_adv is set.
module eth_pcs_prbs31_gen
  import eth_pcs_tx_scrambler_pkg::*;
#(
  parameter int                    W_DATA = 32,
  parameter int                    W_SYNC = 2,
  parameter logic [PRBS_LEN-1:0]   SEED   = 31'h7FFF_FFFF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_adv,
  input  logic                     i_wide,
  output logic [W_DATA+W_SYNC-1:0] o_pat
);

  localparam int W_MAX = W_DATA + W_SYNC;

  // r_state[j] is the sequence bit emitted j+1 positions before the next one.
  logic [PRBS_LEN-1:0] r_state;
  logic [PRBS_LEN-1:0] w_next_wide;
  logic [PRBS_LEN-1:0] w_next_narrow;

  always_comb begin : p_lfsr
    logic [PRBS_LEN+W_MAX-1:0] v_e;
    v_e = '0;
    for (int k = 0; k < PRBS_LEN; k++) begin
      v_e[k] = r_state[PRBS_LEN-1-k];
    end
    for (int n = 0; n < W_MAX; n++) begin
      v_e[PRBS_LEN+n] = v_e[PRBS_LEN+n-PRBS_TAP] ^ v_e[n];
    end
    o_pat = '0;
    for (int n = 0; n < W_MAX; n++) begin
      o_pat[W_MAX-1-n] = v_e[PRBS_LEN+n];
    end
    w_next_wide   = '0;
    w_next_narrow = '0;
    for (int j = 0; j < PRBS_LEN; j++) begin
      w_next_wide[j]   = v_e[PRBS_LEN+W_MAX-1-j];
      w_next_narrow[j] = v_e[PRBS_LEN+W_DATA-1-j];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= SEED;
    end else if (i_adv) begin
      r_state <= i_wide ? w_next_wide : w_next_narrow;
    end
  end

endmodule

// File: rtl/eth_pcs_tx_scrambler.sv
// TX PCS scrambler: self-synchronous 1+x^39+x^58 payload scrambler with PRBS31
// test-pattern and bypass modes, stepped by the gearbox clock enable.
module eth_pcs_tx_scrambler
  import eth_pcs_tx_scrambler_pkg::*;
#(
  parameter int                  W_DATA          = 32,
  parameter int                  W_SYNC          = 2,
  parameter int                  W_TRANS_PER_BLK = 1,
  parameter logic [SCR_LEN-1:0]  SCR_SEED        = 58'h3FF_FFFF_FFFF_FFFF,
  parameter logic [PRBS_LEN-1:0] PRBS_SEED       = 31'h7FFF_FFFF
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clk_en,
  input  logic [W_TRANS_PER_BLK-1:0] i_trans_cnt,
  input  logic [1:0]                 i_mode,
  input  logic [W_SYNC-1:0]          i_sync_data,
  input  logic [W_DATA-1:0]          i_data,
  output logic [W_SYNC-1:0]          o_sync_data,
  output logic [W_DATA-1:0]          o_scr_data,
  output logic [1:0]                 o_mode
);

  localparam int W_MAX = W_DATA + W_SYNC;

  tx_test_mode_e     r_mode;
  logic [SCR_LEN-1:0] r_scr;

  logic               w_first;
  logic               w_last;
  logic               w_scr_adv;
  logic               w_prbs_adv;
  logic [W_DATA-1:0]  w_scr_data;
  logic [SCR_LEN-1:0] w_scr_next;
  logic [W_MAX-1:0]   w_pat;

  assign w_first    = (i_trans_cnt == '0);
  assign w_last     = (i_trans_cnt == '1);
  assign w_scr_adv  = i_clk_en && (r_mode == TX_MODE_NORMAL);
  assign w_prbs_adv = i_clk_en && (r_mode == TX_MODE_PRBS31);

  // r_scr[j] is the scrambled bit sent j+1 positions before this word's first bit;
  // later bits in the word may tap earlier bits of the same word.
  always_comb begin : p_scramble
    logic [SCR_LEN+W_DATA-1:0] v_e;
    v_e = '0;
    for (int k = 0; k < SCR_LEN; k++) begin
      v_e[k] = r_scr[SCR_LEN-1-k];
    end
    for (int n = 0; n < W_DATA; n++) begin
      v_e[SCR_LEN+n] = i_data[W_DATA-1-n] ^ v_e[SCR_LEN+n-SCR_TAP] ^ v_e[n];
    end
    w_scr_data = '0;
    for (int n = 0; n < W_DATA; n++) begin
      w_scr_data[W_DATA-1-n] = v_e[SCR_LEN+n];
    end
    w_scr_next = '0;
    for (int j = 0; j < SCR_LEN; j++) begin
      w_scr_next[j] = v_e[SCR_LEN+W_DATA-1-j];
    end
  end

  eth_pcs_prbs31_gen #(
    .W_DATA (W_DATA),
    .W_SYNC (W_SYNC),
    .SEED   (PRBS_SEED)
  ) u_prbs (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_adv   (w_prbs_adv),
    .i_wide  (w_first),
    .o_pat   (w_pat)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_scr  <= SCR_SEED;
      r_mode <= TX_MODE_NORMAL;
    end else begin
      if (w_scr_adv) begin
        r_scr <= w_scr_next;
      end
      // Mode changes only take effect at a block boundary.
      if (i_clk_en && w_last) begin
        r_mode <= to_tx_mode(i_mode);
      end
    end
  end

  always_comb begin
    o_sync_data = '0;
    o_scr_data  = '0;
    o_mode      = TX_MODE_NORMAL;
    if (i_reset) begin
      o_mode = r_mode;
      case (r_mode)
        TX_MODE_PRBS31: begin
          if (w_first) begin
            {o_sync_data, o_scr_data} = w_pat;
          end else begin
            o_scr_data = w_pat[W_MAX-1 -: W_DATA];
          end
        end
        TX_MODE_BYPASS: begin
          o_sync_data = i_sync_data;
          o_scr_data  = i_data;
        end
        default: begin
          o_sync_data = i_sync_data;
          o_scr_data  = w_scr_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_pcs_tx_scrambler.sv
// Directed bench for eth_pcs_tx_scrambler: bit-stream reference model compared
// every cycle, literal anchors for seeds, plus descrambler recovery.
module tb_eth_pcs_tx_scrambler;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [0:0]  tc;
  logic [1:0]  mode;
  logic [1:0]  sync_i;
  logic [W-1:0] data_i;
  logic [1:0]  o_sync;
  logic [W-1:0] o_scr;
  logic [1:0]  o_mode;

  always #5 clk = ~clk;

  eth_pcs_tx_scrambler dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_clk_en    (ce),
    .i_trans_cnt (tc),
    .i_mode      (mode),
    .i_sync_data (sync_i),
    .i_data      (data_i),
    .o_sync_data (o_sync),
    .o_scr_data  (o_scr),
    .o_mode      (o_mode)
  );

  int n_vec = 0;
  int n_err = 0;

  bit          chk_en = 1'b0;
  logic [1:0]  exp_sync;
  logic [1:0]  exp_mode;
  logic [W-1:0] exp_data;

  // Model state: raw bit streams, newest bit at the back.
  bit scr_h[$];
  bit prbs_h[$];
  bit ds_h[$];
  int m_mode;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    scr_h.delete();
    prbs_h.delete();
    ds_h.delete();
    repeat (58) scr_h.push_back(1'b1);
    repeat (58) ds_h.push_back(1'b1);
    repeat (31) prbs_h.push_back(1'b1);
    m_mode = 0;
  endtask

  task automatic model_step(input bit rst, input bit c, input int t, input int md,
                            input logic [1:0] sy, input logic [W-1:0] d);
    bit tmp[$];
    bit bits[$];
    bit p;
    int cnt;
    if (!rst) begin
      exp_sync = 2'b00;
      exp_data = '0;
      exp_mode = 2'b00;
      model_reset();
      return;
    end
    exp_mode = m_mode[1:0];
    case (m_mode)
      1: begin
        cnt = (t == 0) ? W + 2 : W;
        tmp = prbs_h;
        for (int i = 0; i < cnt; i++) begin
          p = tmp[tmp.size()-28] ^ tmp[tmp.size()-31];
          tmp.push_back(p);
          bits.push_back(p);
        end
        if (t == 0) begin
          exp_sync = {bits[0], bits[1]};
          for (int i = 0; i < W; i++) exp_data[W-1-i] = bits[2+i];
        end else begin
          exp_sync = 2'b00;
          for (int i = 0; i < W; i++) exp_data[W-1-i] = bits[i];
        end
        if (c) begin
          prbs_h = tmp;
          while (prbs_h.size() > 31) void'(prbs_h.pop_front());
        end
      end
      2: begin
        exp_sync = sy;
        exp_data = d;
      end
      default: begin
        tmp = scr_h;
        for (int n = 0; n < W; n++) begin
          p = d[W-1-n] ^ tmp[tmp.size()-39] ^ tmp[tmp.size()-58];
          tmp.push_back(p);
          exp_data[W-1-n] = p;
        end
        exp_sync = sy;
        if (c) begin
          scr_h = tmp;
          while (scr_h.size() > 58) void'(scr_h.pop_front());
        end
      end
    endcase
    if (c && t == 1) m_mode = (md == 3) ? 0 : md;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_data", o_scr, exp_data);
      check("model_sync", {30'b0, o_sync}, {30'b0, exp_sync});
      check("model_mode", {30'b0, o_mode}, {30'b0, exp_mode});
    end
  end

  task automatic xfer(input bit rst, input bit c, input int t, input int md,
                      input logic [1:0] sy, input logic [W-1:0] d,
                      output logic [1:0] gs, output logic [W-1:0] gd);
    @(posedge clk);
    #1;
    rst_n  = rst;
    ce     = c;
    tc     = t[0:0];
    mode   = md[1:0];
    sync_i = sy;
    data_i = d;
    model_step(rst, c, t, md, sy, d);
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    gs = o_sync;
    gd = o_scr;
  endtask

  task automatic descramble(input logic [W-1:0] s, output logic [W-1:0] d);
    bit b;
    for (int n = 0; n < W; n++) begin
      b = s[W-1-n];
      d[W-1-n] = b ^ ds_h[ds_h.size()-39] ^ ds_h[ds_h.size()-58];
      ds_h.push_back(b);
    end
    while (ds_h.size() > 58) void'(ds_h.pop_front());
  endtask

  int run_cur = 0;
  int run_max = 0;
  task automatic track_run(input bit b);
    if (b) begin
      run_cur++;
      if (run_cur > run_max) run_max = run_cur;
    end else begin
      run_cur = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   gs;
    logic [W-1:0] gd;
    logic [W-1:0] rd;
    logic [W-1:0] rnd;
    int cyc;

    rst_n = 1'b0; ce = 1'b0; tc = '0; mode = 2'b00; sync_i = 2'b00; data_i = '0;
    model_reset();

    // Reset with inputs idle, then with active inputs: outputs must be zero.
    xfer(0, 0, 0, 0, 2'b00, '0, gs, gd);
    check("rst_data", gd, 32'h0);
    check("rst_mode", {30'b0, o_mode}, 32'h0);
    xfer(0, 1, 1, 1, 2'b11, 32'hFFFF_FFFF, gs, gd);
    check("rst_data_active", gd, 32'h0);
    check("rst_sync_active", {30'b0, gs}, 32'h0);

    // Seeded scrambler with zero payload.
    xfer(1, 1, 0, 0, 2'b01, '0, gs, gd);
    check("t2_w0", gd, 32'h0000_0000);
    check("t2_sync", {30'b0, gs}, 32'h1);
    xfer(1, 1, 1, 0, 2'b10, '0, gs, gd);
    check("t2_w1", gd, 32'h01FF_FFC0);

    // PRBS31 requested at transfer 0: normal block continues, PRBS from next block.
    xfer(1, 1, 0, 1, 2'b01, 32'h1234_5678, gs, gd);
    check("t4_mode_hold0", {30'b0, o_mode}, 32'h0);
    xfer(1, 1, 1, 1, 2'b10, 32'h9ABC_DEF0, gs, gd);
    check("t4_mode_hold1", {30'b0, o_mode}, 32'h0);
    xfer(1, 1, 0, 1, 2'b01, $urandom, gs, gd);
    check("t4_prbs_first", gd, 32'h0000_0038);
    check("t4_prbs_sync", {30'b0, gs}, 32'h0);
    check("t4_prbs_mode", {30'b0, o_mode}, 32'h1);
    track_run(gs[1]); track_run(gs[0]);
    for (int i = W-1; i >= 0; i--) track_run(gd[i]);
    xfer(1, 1, 1, 1, 2'b00, $urandom, gs, gd);
    for (int i = W-1; i >= 0; i--) track_run(gd[i]);
    for (int blk = 0; blk < 40; blk++) begin
      for (int t = 0; t < 2; t++) begin
        if (blk % 7 == 3) xfer(1, 0, t, 1, 2'b01, $urandom, gs, gd);
        xfer(1, 1, t, (blk == 39) ? 2 : 1, 2'b01, $urandom, gs, gd);
        if (t == 0) begin
          track_run(gs[1]); track_run(gs[0]);
        end
        for (int i = W-1; i >= 0; i--) track_run(gd[i]);
      end
    end
    n_vec++;
    if (run_max > 31 || run_max < 1) begin
      n_err++;
      $display("FAIL prbs_runmax: got %0d want 1..31", run_max);
    end

    // Bypass block (second transfer requests the undefined encoding -> normal).
    xfer(1, 1, 0, 2, 2'b10, 32'hDEAD_BEEF, gs, gd);
    check("t5_byp_data0", gd, 32'hDEAD_BEEF);
    check("t5_byp_sync0", {30'b0, gs}, 32'h2);
    xfer(1, 1, 1, 3, 2'b10, 32'hDEAD_BEEF, gs, gd);
    check("t5_byp_data1", gd, 32'hDEAD_BEEF);
    check("t5_byp_mode", {30'b0, o_mode}, 32'h2);
    xfer(1, 1, 0, 0, 2'b01, 32'hCAFE_F00D, gs, gd);
    check("t5_back_mode", {30'b0, o_mode}, 32'h0);
    xfer(1, 0, 1, 0, 2'b10, 32'h0F0F_0F0F, gs, gd);
    xfer(1, 1, 1, 1, 2'b10, 32'h0F0F_0F0F, gs, gd);

    // PRBS block interrupted by reset at transfer 1.
    xfer(1, 1, 0, 1, 2'b01, $urandom, gs, gd);
    xfer(0, 1, 1, 1, 2'b01, $urandom, gs, gd);
    check("t6_rst_data", gd, 32'h0);
    check("t6_rst_sync", {30'b0, gs}, 32'h0);
    xfer(1, 1, 0, 0, 2'b01, '0, gs, gd);
    check("t6_norm_w0", gd, 32'h0);
    check("t6_norm_mode", {30'b0, o_mode}, 32'h0);
    xfer(1, 1, 1, 1, 2'b10, '0, gs, gd);
    check("t6_norm_w1", gd, 32'h01FF_FFC0);
    xfer(1, 1, 0, 1, 2'b01, '0, gs, gd);
    check("t6_prbs_seed", gd, 32'h0000_0038);
    xfer(1, 1, 1, 0, 2'b01, '0, gs, gd);

    // Random blocks through scrambler and reference descrambler, with stalls.
    xfer(0, 0, 0, 0, 2'b00, '0, gs, gd);
    cyc = 0;
    for (int blk = 0; blk < 1000; blk++) begin
      for (int t = 0; t < 2; t++) begin
        cyc++;
        if (cyc % 33 == 0) begin
          xfer(1, 0, t, 0, 2'b10, $urandom, gs, gd);
          cyc++;
        end
        rnd = $urandom;
        xfer(1, 1, t, 0, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, rnd, gs, gd);
        descramble(gd, rd);
        check("descramble", rd, rnd);
      end
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
